// File: rtl/intercon_bus_ctrl_if.sv
// Bus-side signal bundle of the round-robin interconnect controller.
// The controller sits on the slave modport; masters/slave drive through the master modport.
`ifndef INTERCON_MASTER_NUM
`define INTERCON_MASTER_NUM 4
`endif

interface intercon_bus_ctrl_if #(
  parameter int unsigned MASTER_NUM = `INTERCON_MASTER_NUM
);
  logic [MASTER_NUM-1:0] m_cyc_i;
  logic                  s_ack_i;
  logic                  s_err_i;
  logic                  s_rty_i;
  logic [MASTER_NUM-1:0] grant_o;
  logic                  cyc_o;
  logic [MASTER_NUM-1:0] last_o;
  logic                  tmo_err_o;

  modport slave (
    input  m_cyc_i, s_ack_i, s_err_i, s_rty_i,
    output grant_o, cyc_o, last_o, tmo_err_o
  );

  modport master (
    output m_cyc_i, s_ack_i, s_err_i, s_rty_i,
    input  grant_o, cyc_o, last_o, tmo_err_o
  );
endinterface

// File: rtl/intercon_bus_ctrl.sv
// Round-robin Wishbone bus controller: registered one-hot grant held for the whole
// bus cycle, priority rotating after each grant, watchdog release of stalled transfers.
`ifndef INTERCON_MASTER_NUM
`define INTERCON_MASTER_NUM 4
`endif

module intercon_bus_ctrl #(
  parameter int unsigned MASTER_NUM = `INTERCON_MASTER_NUM,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  intercon_bus_ctrl_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(MASTER_NUM);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [MASTER_NUM-1:0] LAST_RST = {1'b1, {(MASTER_NUM-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

  state_t                r_state,    w_state_nxt;
  logic [MASTER_NUM-1:0] r_grant,    w_grant_nxt;
  logic [MASTER_NUM-1:0] r_last,     w_last_nxt;
  logic [IDX_W-1:0]      r_last_idx, w_last_idx_nxt;
  logic                  r_cyc,      w_cyc_nxt;
  logic                  r_tmo,      w_tmo_nxt;
  logic [CNT_W-1:0]      r_cnt,      w_cnt_nxt;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_term;

  assign w_term = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

  // Nearest requester after the last owner wins; scanning farthest-first lets the nearest overwrite.
  always_comb begin : arb
    w_win_idx = r_last_idx;
    for (int d = int'(MASTER_NUM); d >= 1; d--) begin
      if (bus.m_cyc_i[IDX_W'((int'(r_last_idx) + d) % int'(MASTER_NUM))]) begin
        w_win_idx = IDX_W'((int'(r_last_idx) + d) % int'(MASTER_NUM));
      end
    end
  end

  always_ff @(posedge clk_i) begin : state_reg
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : next_state
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_nxt     = r_last;
    w_last_idx_nxt = r_last_idx;
    w_cyc_nxt      = r_cyc;
    w_cnt_nxt      = r_cnt;
    w_tmo_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|bus.m_cyc_i) begin
          w_grant_nxt    = MASTER_NUM'(1) << w_win_idx;
          w_last_nxt     = MASTER_NUM'(1) << w_win_idx;
          w_last_idx_nxt = w_win_idx;
          w_cyc_nxt      = 1'b1;
          w_cnt_nxt      = '0;
          w_state_nxt    = S_BUSY;
        end
      end
      S_BUSY: begin
        // Owner drop beats termination, which beats watchdog expiry.
        if (!bus.m_cyc_i[r_last_idx]) begin
          w_grant_nxt = '0;
          w_cyc_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_term) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_tmo_nxt   = 1'b1;
          w_grant_nxt = '0;
          w_cyc_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (!bus.m_cyc_i[r_last_idx]) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin : out_regs
    if (rst_i) begin
      r_grant    <= '0;
      r_last     <= LAST_RST;
      r_last_idx <= IDX_W'(MASTER_NUM - 1);
      r_cyc      <= 1'b0;
      r_tmo      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_grant    <= w_grant_nxt;
      r_last     <= w_last_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_cyc      <= w_cyc_nxt;
      r_tmo      <= w_tmo_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign bus.grant_o   = r_grant;
  assign bus.cyc_o     = r_cyc;
  assign bus.last_o    = r_last;
  assign bus.tmo_err_o = r_tmo;

endmodule

// File: tb/tb_intercon_bus_ctrl.sv
// Directed bench for intercon_bus_ctrl: grants are predicted into a queue as
// requests are driven and popped by a monitor whenever a new bus cycle starts.
module tb_intercon_bus_ctrl;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 8;

  logic clk_i = 1'b0;
  logic rst_i;

  intercon_bus_ctrl_if #(.MASTER_NUM(N)) bus ();

  intercon_bus_ctrl #(.MASTER_NUM(N), .TIMEOUT(TMO)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;
  logic [N-1:0] exp_q[$];
  logic         prev_cyc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pop a predicted grant at each new bus cycle; check bus invariants every cycle.
  always @(posedge clk_i) begin
    #1;
    if (!rst_i) begin
      chk("cyc_eq_or_grant", 32'(bus.cyc_o), 32'(|bus.grant_o));
      chk("grant_onehot0", 32'($countones(bus.grant_o) <= 1), 32'(1));
    end
    if (bus.cyc_o && !prev_cyc) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 32'(bus.grant_o), 32'(0));
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        chk("sb_grant", 32'(bus.grant_o), 32'(e));
        chk("sb_last", 32'(bus.last_o), 32'(e));
      end
    end
    prev_cyc = bus.cyc_o;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [N-1:0] owner;
    rst_i         = 1'b1;
    bus.m_cyc_i   = '0;
    bus.s_ack_i   = 1'b0;
    bus.s_err_i   = 1'b0;
    bus.s_rty_i   = 1'b0;
    tick(); tick(); tick();
    rst_i = 1'b0;
    tick();
    chk("rst_grant", 32'(bus.grant_o), 32'(0));
    chk("rst_cyc", 32'(bus.cyc_o), 32'(0));
    chk("rst_tmo", 32'(bus.tmo_err_o), 32'(0));
    chk("rst_last", 32'(bus.last_o), 32'(4'b1000));

    // Reset priority, then rotation with one idle cycle between owners.
    bus.m_cyc_i = 4'b1111;
    bus.s_ack_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      owner = 4'b0001 << (i % 4);
      exp_q.push_back(owner);
      tick();
      chk("rot_grant", 32'(bus.grant_o), 32'(owner));
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("rot_hold", 32'(bus.grant_o), 32'(owner));
      end
      bus.m_cyc_i = 4'b1111 & ~owner;
      tick();
      chk("rot_idle_gap", 32'(bus.cyc_o), 32'(0));
      bus.m_cyc_i = 4'b1111;
    end
    bus.m_cyc_i = '0;
    tick();
    chk("rot_last", 32'(bus.last_o), 32'(4'b0001));

    // Master 2 alone, then re-requesting as sole last owner.
    bus.m_cyc_i = 4'b0100;
    exp_q.push_back(4'b0100);
    tick();
    tick();
    bus.m_cyc_i = 4'b0000;
    tick();
    chk("sole_idle", 32'(bus.grant_o), 32'(0));
    chk("sole_last", 32'(bus.last_o), 32'(4'b0100));
    bus.m_cyc_i = 4'b0100;
    exp_q.push_back(4'b0100);
    tick();
    chk("sole_regrant", 32'(bus.grant_o), 32'(4'b0100));
    bus.m_cyc_i = '0;
    tick();

    // No preemption of master 3 by master 0.
    bus.m_cyc_i = 4'b1000;
    exp_q.push_back(4'b1000);
    tick();
    bus.m_cyc_i = 4'b1001;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("nopreempt_hold", 32'(bus.grant_o), 32'(4'b1000));
    end
    bus.m_cyc_i = 4'b0001;
    tick();
    chk("nopreempt_release", 32'(bus.grant_o), 32'(0));
    exp_q.push_back(4'b0001);
    tick();
    chk("nopreempt_next", 32'(bus.grant_o), 32'(4'b0001));
    bus.m_cyc_i = '0;
    bus.s_ack_i = 1'b0;
    tick();

    // Watchdog on master 1, then drain while master 2 waits.
    bus.m_cyc_i = 4'b0010;
    exp_q.push_back(4'b0010);
    tick();
    for (int j = 1; j < int'(TMO); j++) begin
      tick();
      chk("wd_pre_tmo", 32'(bus.tmo_err_o), 32'(0));
      chk("wd_pre_grant", 32'(bus.grant_o), 32'(4'b0010));
    end
    tick();
    chk("wd_tmo_pulse", 32'(bus.tmo_err_o), 32'(1));
    chk("wd_tmo_grant", 32'(bus.grant_o), 32'(0));
    bus.m_cyc_i = 4'b0110;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("wd_drain_tmo", 32'(bus.tmo_err_o), 32'(0));
      chk("wd_drain_grant", 32'(bus.grant_o), 32'(0));
    end
    bus.m_cyc_i = 4'b0100;
    tick();
    chk("wd_drain_exit", 32'(bus.grant_o), 32'(0));
    exp_q.push_back(4'b0100);
    tick();
    chk("wd_next_grant", 32'(bus.grant_o), 32'(4'b0100));

    // Termination on the expiry cycle suppresses the timeout.
    for (int j = 1; j < int'(TMO); j++) tick();
    bus.s_ack_i = 1'b1;
    tick();
    chk("term_at_expiry_tmo", 32'(bus.tmo_err_o), 32'(0));
    chk("term_at_expiry_grant", 32'(bus.grant_o), 32'(4'b0100));
    bus.s_ack_i = 1'b0;
    // cyc drop on the expiry cycle wins over the timeout.
    for (int j = 1; j < int'(TMO); j++) tick();
    bus.m_cyc_i = '0;
    tick();
    chk("drop_at_expiry_tmo", 32'(bus.tmo_err_o), 32'(0));
    chk("drop_at_expiry_grant", 32'(bus.grant_o), 32'(0));
    tick();
    chk("drop_no_late_tmo", 32'(bus.tmo_err_o), 32'(0));

    // Reset mid-burst with master 1 owning the bus.
    bus.m_cyc_i = 4'b0010;
    bus.s_ack_i = 1'b1;
    exp_q.push_back(4'b0010);
    tick();
    tick();
    chk("pre_rst_last", 32'(bus.last_o), 32'(4'b0010));
    rst_i = 1'b1;
    tick();
    chk("midrst_grant", 32'(bus.grant_o), 32'(0));
    chk("midrst_cyc", 32'(bus.cyc_o), 32'(0));
    chk("midrst_last", 32'(bus.last_o), 32'(4'b1000));
    rst_i = 1'b0;
    bus.m_cyc_i = 4'b1111;
    exp_q.push_back(4'b0001);
    tick();
    chk("post_rst_grant", 32'(bus.grant_o), 32'(4'b0001));
    bus.m_cyc_i = '0;
    bus.s_ack_i = 1'b0;
    tick();
    tick();

    chk("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
